// File: rtl/cart_led_controller.sv
// rtl/cart_led_controller.sv - cart activity LED arbiter: activity stretch, blink-code errors, host override
module cart_led_controller #(
    parameter int NUM_SOURCES     = 4,
    parameter int TICK_DIV        = 100000,
    parameter int ACT_TICKS       = 32,
    parameter int BLINK_ON_TICKS  = 16,
    parameter int BLINK_OFF_TICKS = 16,
    parameter int GAP_TICKS       = 64
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_SOURCES-1:0] i_activity,
    input  logic [NUM_SOURCES-1:0] i_activity_mask,
    input  logic                   i_error_valid,
    input  logic [3:0]             i_error_code,
    input  logic                   i_override_en,
    input  logic                   i_override_value,
    output logic                   o_led,
    output logic                   o_error_active
);

    localparam int DIV_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_act;
    state_t           state, state_nx;
    logic [7:0]       phase, phase_nx;
    logic [3:0]       remaining, remaining_nx;
    logic [3:0]       code, code_nx;
    logic             tick;
    logic             hit;
    logic             load;

    assign tick = (r_div == DIV_W'(TICK_DIV - 1));
    assign hit  = |(i_activity & i_activity_mask);
    assign load = i_error_valid && (i_error_code != 4'd0);

    // Restarting the prescaler on a code load makes every phase an exact multiple of TICK_DIV.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div <= '0;
        end else if (load || tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_act <= 8'd0;
        end else if (hit) begin
            r_act <= 8'(ACT_TICKS);
        end else if (tick && (r_act != 8'd0)) begin
            r_act <= r_act - 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            phase     <= 8'd0;
            remaining <= 4'd0;
            code      <= 4'd0;
        end else begin
            state     <= state_nx;
            phase     <= phase_nx;
            remaining <= remaining_nx;
            code      <= code_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        phase_nx     = phase;
        remaining_nx = remaining;
        code_nx      = code;
        if (i_error_valid) begin
            if (i_error_code == 4'd0) begin
                state_nx = IDLE;
            end else begin
                code_nx      = i_error_code;
                remaining_nx = i_error_code;
                phase_nx     = 8'(BLINK_ON_TICKS);
                state_nx     = ON;
            end
        end else if ((state != IDLE) && tick) begin
            if (phase == 8'd1) begin
                case (state)
                    ON: begin
                        remaining_nx = remaining - 4'd1;
                        phase_nx     = 8'(BLINK_OFF_TICKS);
                        state_nx     = OFF;
                    end
                    OFF: begin
                        if (remaining == 4'd0) begin
                            phase_nx = 8'(GAP_TICKS);
                            state_nx = GAP;
                        end else begin
                            phase_nx = 8'(BLINK_ON_TICKS);
                            state_nx = ON;
                        end
                    end
                    GAP: begin
                        remaining_nx = code;
                        phase_nx     = 8'(BLINK_ON_TICKS);
                        state_nx     = ON;
                    end
                    default: state_nx = IDLE;
                endcase
            end else begin
                phase_nx = phase - 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_led          <= 1'b0;
            o_error_active <= 1'b0;
        end else begin
            if (i_override_en) begin
                o_led <= i_override_value;
            end else if (state != IDLE) begin
                o_led <= (state == ON);
            end else begin
                o_led <= (r_act != 8'd0);
            end
            o_error_active <= (state_nx != IDLE);
        end
    end

endmodule
